// File: rtl/apb_top.sv
// ---------------------------------------------------------------------------
// apb_top -- APB master/slave pair in one block.
//
// A request on start/addr/data/write is turned into an APB transfer
// (SETUP then ACCESS) by a small master FSM.  The transfer targets an
// internal 2**ADDR_W x DATA_W register-file slave.  Reads return the
// slave word on rdata.  done pulses for the one cycle following each
// completed transfer.
//
// Ports
//   clk    i  single clock, rising edge
//   rst_n  i  asynchronous active-low reset (clears FSM, regs, memory)
//   start  i  transfer request
//   addr   i  [ADDR_W] word address
//   data   i  [DATA_W] write data
//   write  i  1 = write, 0 = read
//   rdata  o  [DATA_W] data of the most recently completed read
//   done   o  one-cycle completion pulse
//   busy   o  master not in IDLE
//
// Build option
//   APB_WAIT_STATE_EN  slave inserts one wait state per transfer, so each
//                      transfer is SETUP + 2 ACCESS cycles.  Undefined:
//                      pready is tied high (SETUP + 1 ACCESS).
// ---------------------------------------------------------------------------
module apb_top #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              write,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // ---------------- internal APB bus ----------------
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    // ---------------- master ----------------
    state_t            state_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        paddr_q   <= addr;
                        pwdata_q  <= data;
                        pwrite_q  <= write;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        done_q <= 1'b1;
                        if (!pwrite_q) rdata_q <= prdata;
                        if (start) begin
                            // back-to-back: next request goes straight to SETUP
                            paddr_q   <= addr;
                            pwdata_q  <= data;
                            pwrite_q  <= write;
                            penable_q <= 1'b0;
                            state_q   <= SETUP;
                        end else begin
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign busy  = busy_q;

    // ---------------- slave ----------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              access;
    logic              wr_en;

    assign access = psel_q && penable_q;
    assign wr_en  = access && pready && pwrite_q;

`ifdef APB_WAIT_STATE_EN
    // wait_q is low on the first ACCESS cycle, high on the second; it
    // falls again at the completing edge so the next transfer waits too.
    logic wait_q;
    logic wait_d;

    assign wait_d = access && !wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= 1'b0;
        else        wait_q <= wait_d;
    end

    assign pready = wait_q;
`else
    assign pready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[paddr_q] <= pwdata_q;
        end
    end

    // Bus is quiet outside ACCESS so an unselected slave returns zero.
    assign prdata = access ? mem_q[paddr_q] : '0;

endmodule

// File: tb/tb_apb_top.sv
module tb_apb_top;

    localparam int AW = 4;
    localparam int DW = 16;
`ifdef APB_WAIT_STATE_EN
    localparam int TX = 3;
`else
    localparam int TX = 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          write;
    logic [DW-1:0] rdata;
    logic          done;
    logic          busy;

    apb_top #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .addr  (addr),
        .data  (data),
        .write (write),
        .rdata (rdata),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct {
        logic [DW-1:0] rd;
        int            c;
    } exp_t;

    req_t          rq[$];
    exp_t          sb[$];
    logic [DW-1:0] model [2**AW];
    logic [DW-1:0] last_rd;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
        last_rd = '0;
    endtask

    // Present a request (caller is at a negedge with the master ready to
    // sample).  Reference: memory array + "last read" register; the done
    // pulse is expected TX cycles after the sampling edge.
    task automatic issue(input req_t r);
        exp_t e;
        start = 1'b1;
        addr  = r.a;
        data  = r.d;
        write = r.w;
        if (r.w) model[r.a] = r.d;
        else     last_rd = model[r.a];
        e.rd = last_rd;
        e.c  = cyc + 1 + TX;
        sb.push_back(e);
    endtask

    // Drains rq as one back-to-back burst; request inputs are scrambled
    // mid-transfer, which the master must ignore.
    task automatic run_burst();
        while (rq.size() != 0) begin
            @(negedge clk);
            issue(rq.pop_front());
            @(posedge clk);
            for (int j = 1; j < TX; j++) begin
                @(negedge clk);
                addr  = AW'($urandom);
                data  = DW'($urandom);
                write = 1'($urandom);
                @(posedge clk);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.w = w; r.a = a; r.d = d;
        rq.push_back(r);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", rdata, e.rd);
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        addr  = '0;
        data  = '0;
        write = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 0);
        chk("reset_done",  done,  0);
        chk("reset_busy",  busy,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // read of a cleared word
        push(1'b0, 4'd5, '0);                run_burst();
        // write then separate read, top address
        push(1'b1, 4'd15, 16'hFACE);         run_burst();
        push(1'b0, 4'd15, '0);               run_burst();
        // back-to-back writes then reads
        push(1'b1, 4'd14, 16'hCAFE);
        push(1'b1, 4'd13, 16'hFFFF);
        push(1'b1, 4'd12, 16'hBEEF);
        push(1'b0, 4'd14, '0);
        push(1'b0, 4'd13, '0);
        push(1'b0, 4'd12, '0);
        run_burst();
        // isolated write with scrambled inputs, then sweep every word
        push(1'b1, 4'd3, 16'h1234);          run_burst();
        for (int i = 0; i < 2**AW; i++) push(1'b0, AW'(i), '0);
        run_burst();
        // addr 9 write/read
        push(1'b1, 4'd9, 16'h5A5A);          run_burst();
        push(1'b0, 4'd9, '0);                run_burst();

        // random bursts with random idle gaps
        for (int b = 0; b < 12; b++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++)
                push(1'($urandom), AW'($urandom), DW'($urandom));
            run_burst();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // reset during ACCESS of a write: busy drops at once, no write lands
        @(negedge clk);
        push(1'b0, 4'd12, '0);               run_burst();
        drain();
        @(negedge clk);
        start = 1'b1; write = 1'b1; addr = 4'd7; data = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  busy,  0);
        chk("abort_done",  done,  0);
        chk("abort_rdata", rdata, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 4'd7, '0);
        push(1'b0, 4'd15, '0);
        push(1'b0, 4'd9, '0);
        run_burst();
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
